// File: rtl/usb2_ep_router.sv
// usb2_ep_router: binds one endpoint per transaction and steers buffer, arm, toggle and halt traffic to it.
// Optional per-endpoint handshake counters are enabled by defining USB2_EP_ROUTER_STATS_EN.
module usb2_ep_router #(
  parameter int unsigned         NUM_EP   = 4,
  parameter int unsigned         ADDR_W   = 11,
  parameter int unsigned         LEN_W    = 11,
  parameter logic [2*NUM_EP-1:0] EP_MODES = {2'd1, 2'd2, 2'd2, 2'd0}
) (
  input  logic                     phy_clk,
  input  logic                     reset_n,
  input  logic [3:0]               sel_endp,
  input  logic                     xfer_start,
  input  logic                     xfer_end,
  output logic                     bound,
  output logic                     ep_invalid,
  output logic [1:0]               endp_mode,
  output logic                     stall,
  input  logic [ADDR_W-1:0]        buf_in_addr,
  input  logic [7:0]               buf_in_data,
  input  logic                     buf_in_wren,
  input  logic                     buf_in_commit,
  input  logic [LEN_W-1:0]         buf_in_commit_len,
  output logic                     buf_in_ready,
  output logic                     buf_in_commit_ack,
  input  logic [ADDR_W-1:0]        buf_out_addr,
  output logic [7:0]               buf_out_q,
  output logic [LEN_W-1:0]         buf_out_len,
  output logic                     buf_out_hasdata,
  input  logic                     buf_out_arm,
  output logic                     buf_out_arm_ack,
  output logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr,
  output logic [NUM_EP*8-1:0]      ep_buf_in_data,
  output logic [NUM_EP-1:0]        ep_buf_in_wren,
  output logic [NUM_EP-1:0]        ep_buf_in_commit,
  output logic [NUM_EP*LEN_W-1:0]  ep_buf_in_commit_len,
  input  logic [NUM_EP-1:0]        ep_buf_in_ready,
  input  logic [NUM_EP-1:0]        ep_buf_in_commit_ack,
  output logic [NUM_EP*ADDR_W-1:0] ep_buf_out_addr,
  input  logic [NUM_EP*8-1:0]      ep_buf_out_q,
  input  logic [NUM_EP*LEN_W-1:0]  ep_buf_out_len,
  input  logic [NUM_EP-1:0]        ep_buf_out_hasdata,
  output logic [NUM_EP-1:0]        ep_buf_out_arm,
  input  logic [NUM_EP-1:0]        ep_buf_out_arm_ack,
  input  logic                     data_toggle_act,
  output logic [1:0]               data_toggle,
  input  logic [3:0]               halt_ep,
  input  logic                     halt_set,
  input  logic                     halt_clr,
  output logic [NUM_EP-1:0]        ep_halted
`ifdef USB2_EP_ROUTER_STATS_EN
  ,
  input  logic [3:0]               stat_sel,
  output logic [15:0]              stat_count
`endif
);

  localparam logic [1:0] MODE_ISOCH = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_BOUND, S_ARM_WAIT, S_ARM_DONE} state_t;

  state_t            state;
  logic [3:0]        cur_ep;
  logic              end_pend;
  logic [NUM_EP-1:0] toggle;
  logic [NUM_EP-1:0] sel;
  logic [1:0]        ep_mode [NUM_EP];

  logic              cur_valid;
  logic              cur_halted;
  logic              cur_tog;
  logic              cur_ready;
  logic              cur_cack;
  logic              cur_hasdata;
  logic              cur_arm_ack;
  logic [1:0]        cur_mode;
  logic [7:0]        cur_q;
  logic [LEN_W-1:0]  cur_len;
  logic              arm_bypass;

  // Per-endpoint transfer type; endpoint 0 is CONTROL regardless of EP_MODES.
  always_comb begin
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      ep_mode[i] = (i == 0) ? 2'd0 : EP_MODES[2*i +: 2];
    end
  end

  // Select the bound endpoint and gather its return signals; an out-of-range number selects nothing.
  always_comb begin
    sel         = '0;
    cur_mode    = 2'd0;
    cur_halted  = 1'b0;
    cur_tog     = 1'b0;
    cur_ready   = 1'b0;
    cur_cack    = 1'b0;
    cur_q       = 8'd0;
    cur_len     = '0;
    cur_hasdata = 1'b0;
    cur_arm_ack = 1'b0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (state != S_IDLE && cur_ep == 4'(i)) begin
        sel[i]      = 1'b1;
        cur_mode    = ep_mode[i];
        cur_halted  = ep_halted[i];
        cur_tog     = toggle[i];
        cur_ready   = ep_buf_in_ready[i];
        cur_cack    = ep_buf_in_commit_ack[i];
        cur_q       = ep_buf_out_q[i*8 +: 8];
        cur_len     = ep_buf_out_len[i*LEN_W +: LEN_W];
        cur_hasdata = ep_buf_out_hasdata[i];
        cur_arm_ack = ep_buf_out_arm_ack[i];
      end
    end
  end

  assign cur_valid         = |sel;
  assign bound             = (state != S_IDLE);
  assign ep_invalid        = bound & ~cur_valid;
  assign endp_mode         = cur_mode;
  assign stall             = ep_invalid | cur_halted;
  assign data_toggle       = {1'b0, cur_tog};
  assign buf_in_ready      = cur_ready & ~cur_halted;
  assign buf_in_commit_ack = cur_cack;
  assign buf_out_q         = cur_q;
  assign buf_out_len       = cur_len;
  assign buf_out_hasdata   = cur_hasdata & ~cur_halted;
  assign buf_out_arm_ack   = (state == S_ARM_DONE);
  // No endpoint will answer an arm for an invalid or halted binding, so the router acks it itself.
  assign arm_bypass        = ~cur_valid | cur_halted;

  // Forward packet-side traffic to the bound endpoint only.
  always_comb begin
    ep_buf_in_addr       = '0;
    ep_buf_in_data       = '0;
    ep_buf_in_wren       = '0;
    ep_buf_in_commit     = '0;
    ep_buf_in_commit_len = '0;
    ep_buf_out_addr      = '0;
    ep_buf_out_arm       = '0;
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      if (sel[i]) begin
        ep_buf_in_addr[i*ADDR_W +: ADDR_W]      = buf_in_addr;
        ep_buf_in_data[i*8 +: 8]                = buf_in_data;
        ep_buf_in_wren[i]                       = buf_in_wren;
        ep_buf_in_commit[i]                     = buf_in_commit;
        ep_buf_in_commit_len[i*LEN_W +: LEN_W]  = buf_in_commit_len;
        ep_buf_out_addr[i*ADDR_W +: ADDR_W]     = buf_out_addr;
        ep_buf_out_arm[i] = ~cur_halted &
                            ((state == S_BOUND && buf_out_arm) || state == S_ARM_WAIT);
      end
    end
  end

  // Transaction binding and arm handshake sequencing.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cur_ep   <= 4'd0;
      end_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          end_pend <= 1'b0;
          if (xfer_start) begin
            cur_ep <= sel_endp;
            state  <= S_BOUND;
          end
        end
        S_BOUND: begin
          if (buf_out_arm) begin
            state    <= arm_bypass ? S_ARM_DONE : S_ARM_WAIT;
            end_pend <= xfer_end;
          end else if (xfer_end) begin
            state <= S_IDLE;
          end
        end
        S_ARM_WAIT: begin
          end_pend <= end_pend | xfer_end;
          if (arm_bypass || cur_arm_ack) state <= S_ARM_DONE;
        end
        S_ARM_DONE: begin
          end_pend <= 1'b0;
          state    <= (end_pend || xfer_end) ? S_IDLE : S_BOUND;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Halt flags and data toggles; a clear resets the toggle unless a set arrives with it.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle    <= '0;
      ep_halted <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        if (i != 0 && halt_ep == 4'(i) && halt_set) begin
          ep_halted[i] <= 1'b1;
        end else if (i != 0 && halt_ep == 4'(i) && halt_clr) begin
          ep_halted[i] <= 1'b0;
        end
        if (i != 0 && halt_ep == 4'(i) && halt_clr && !halt_set) begin
          toggle[i] <= 1'b0;
        end else if (state == S_BOUND && sel[i] && data_toggle_act && ep_mode[i] != MODE_ISOCH) begin
          toggle[i] <= ~toggle[i];
        end
      end
    end
  end

`ifdef USB2_EP_ROUTER_STATS_EN
  logic [15:0] stat_cnt [NUM_EP];
  logic [16:0] stat_sum [NUM_EP];
  logic        arm_done_evt;

  assign arm_done_evt = (state == S_ARM_WAIT) & cur_valid & ~cur_halted & cur_arm_ack;

  // Up to two handshakes (arm and commit) may complete in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      stat_sum[i] = 17'(stat_cnt[i]) + 17'(arm_done_evt & sel[i])
                  + 17'(sel[i] & ep_buf_in_commit_ack[i]);
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_EP; i++) stat_cnt[i] <= 16'd0;
      stat_count <= 16'd0;
    end else begin
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        stat_cnt[i] <= stat_sum[i][16] ? 16'hFFFF : stat_sum[i][15:0];
      end
      stat_count <= 16'd0;
      for (int unsigned i = 0; i < NUM_EP; i++) begin
        if (stat_sel == 4'(i)) stat_count <= stat_cnt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb2_ep_router.sv
// Self-checking bench for usb2_ep_router: routing table, arm/toggle/halt sequences, and a randomized model run.
module tb_usb2_ep_router;

  localparam int unsigned NUM_EP = 4;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LEN_W  = 11;

  logic phy_clk = 1'b0;
  logic reset_n;
  always #5 phy_clk = ~phy_clk;

  logic [3:0]               sel_endp;
  logic                     xfer_start, xfer_end;
  logic                     bound, ep_invalid, stall;
  logic [1:0]               endp_mode;
  logic [ADDR_W-1:0]        buf_in_addr, buf_out_addr;
  logic [7:0]               buf_in_data, buf_out_q;
  logic                     buf_in_wren, buf_in_commit, buf_in_ready, buf_in_commit_ack;
  logic [LEN_W-1:0]         buf_in_commit_len, buf_out_len;
  logic                     buf_out_hasdata, buf_out_arm, buf_out_arm_ack;
  logic [NUM_EP*ADDR_W-1:0] ep_buf_in_addr, ep_buf_out_addr;
  logic [NUM_EP*8-1:0]      ep_buf_in_data, ep_buf_out_q;
  logic [NUM_EP-1:0]        ep_buf_in_wren, ep_buf_in_commit, ep_buf_in_ready, ep_buf_in_commit_ack;
  logic [NUM_EP*LEN_W-1:0]  ep_buf_in_commit_len, ep_buf_out_len;
  logic [NUM_EP-1:0]        ep_buf_out_hasdata, ep_buf_out_arm, ep_buf_out_arm_ack;
  logic                     data_toggle_act;
  logic [1:0]               data_toggle;
  logic [3:0]               halt_ep;
  logic                     halt_set, halt_clr;
  logic [NUM_EP-1:0]        ep_halted;
`ifdef USB2_EP_ROUTER_STATS_EN
  logic [3:0]               stat_sel;
  logic [15:0]              stat_count;
`endif

  usb2_ep_router #(.NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .sel_endp(sel_endp), .xfer_start(xfer_start), .xfer_end(xfer_end),
    .bound(bound), .ep_invalid(ep_invalid), .endp_mode(endp_mode), .stall(stall),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .ep_buf_in_addr(ep_buf_in_addr), .ep_buf_in_data(ep_buf_in_data), .ep_buf_in_wren(ep_buf_in_wren),
    .ep_buf_in_commit(ep_buf_in_commit), .ep_buf_in_commit_len(ep_buf_in_commit_len),
    .ep_buf_in_ready(ep_buf_in_ready), .ep_buf_in_commit_ack(ep_buf_in_commit_ack),
    .ep_buf_out_addr(ep_buf_out_addr), .ep_buf_out_q(ep_buf_out_q), .ep_buf_out_len(ep_buf_out_len),
    .ep_buf_out_hasdata(ep_buf_out_hasdata), .ep_buf_out_arm(ep_buf_out_arm),
    .ep_buf_out_arm_ack(ep_buf_out_arm_ack),
    .data_toggle_act(data_toggle_act), .data_toggle(data_toggle),
    .halt_ep(halt_ep), .halt_set(halt_set), .halt_clr(halt_clr), .ep_halted(ep_halted)
`ifdef USB2_EP_ROUTER_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic pkt_idle();
    sel_endp = 4'd0; xfer_start = 1'b0; xfer_end = 1'b0;
    buf_in_addr = '0; buf_in_data = 8'd0; buf_in_wren = 1'b0; buf_in_commit = 1'b0;
    buf_in_commit_len = '0; buf_out_addr = '0; buf_out_arm = 1'b0;
    data_toggle_act = 1'b0; halt_ep = 4'd0; halt_set = 1'b0; halt_clr = 1'b0;
`ifdef USB2_EP_ROUTER_STATS_EN
    stat_sel = 4'd0;
`endif
  endtask

  task automatic ep_defaults();
    ep_buf_out_q         = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ep_buf_out_len       = {11'd103, 11'd102, 11'd101, 11'd100};
    ep_buf_out_hasdata   = 4'b1011;
    ep_buf_in_ready      = 4'b1111;
    ep_buf_in_commit_ack = 4'b0000;
    ep_buf_out_arm_ack   = 4'b0000;
  endtask

  task automatic bind_ep(input logic [3:0] e);
    sel_endp = e; xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic unbind();
    xfer_end = 1'b1;
    tick();
    xfer_end = 1'b0;
  endtask

  function automatic logic any_ep_out();
    return |{ep_buf_in_addr, ep_buf_in_data, ep_buf_in_wren, ep_buf_in_commit,
             ep_buf_in_commit_len, ep_buf_out_addr, ep_buf_out_arm};
  endfunction

  typedef struct {
    logic [3:0] sel;
    logic       inv;
    logic [1:0] mode;
    logic [7:0] q;
    logic       hd;
  } vec_t;

  vec_t vecs [6];

  // Reference model state for the randomized run.
  bit  m_bound;
  int  m_ep;
  bit  m_tog  [NUM_EP];
  bit  m_halt [NUM_EP];
  int  mode_tab [NUM_EP] = '{0, 2, 2, 1};

  logic [NUM_EP*ADDR_W-1:0] e_addr, e_oaddr;
  logic [NUM_EP*8-1:0]      e_data;
  logic [NUM_EP-1:0]        e_wren, e_commit, e_halted;
  logic [NUM_EP*LEN_W-1:0]  e_clen;

  initial begin
    int arm_seen, acks, other, ack_cyc, given_cyc, he;
    bit e_valid;
    logic [2:0] tog_exp;

    vecs[0] = '{4'd0,  1'b0, 2'd0, 8'hA0, 1'b1};
    vecs[1] = '{4'd1,  1'b0, 2'd2, 8'hA1, 1'b1};
    vecs[2] = '{4'd2,  1'b0, 2'd2, 8'hA2, 1'b0};
    vecs[3] = '{4'd3,  1'b0, 2'd1, 8'hA3, 1'b1};
    vecs[4] = '{4'd9,  1'b1, 2'd0, 8'h00, 1'b0};
    vecs[5] = '{4'd15, 1'b1, 2'd0, 8'h00, 1'b0};

    reset_n = 1'b0;
    pkt_idle();
    ep_defaults();
    repeat (2) @(posedge phy_clk);
    @(negedge phy_clk);
    check("rst_bound", bound, 0);
    check("rst_invalid", ep_invalid, 0);
    check("rst_mode", endp_mode, 0);
    check("rst_stall", stall, 0);
    check("rst_toggle", data_toggle, 0);
    check("rst_halted", ep_halted, 0);
    check("rst_arm_ack", buf_out_arm_ack, 0);
    check("rst_ep_outs", any_ep_out(), 0);
    check("rst_q", buf_out_q, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_bound", bound, 0);

`ifdef USB2_EP_ROUTER_STATS_EN
    bind_ep(4'd2);
    for (int k = 0; k < 5; k++) begin
      buf_in_commit = 1'b1; ep_buf_in_commit_ack = 4'b0100;
      tick();
      buf_in_commit = 1'b0; ep_buf_in_commit_ack = 4'b0000;
      tick();
    end
    stat_sel = 4'd1;
    tick();
    stat_sel = 4'd2;
    @(negedge phy_clk);
    check("stat_latency", stat_count, 0);
    tick();
    @(negedge phy_clk);
    check("stat_ep2", stat_count, 5);
    tick();
    unbind();
`endif

    // Routing table.
    for (int v = 0; v < 6; v++) begin
      buf_in_addr = 11'h155;
      bind_ep(vecs[v].sel);
      @(negedge phy_clk);
      e_addr = '0;
      if (!vecs[v].inv) e_addr[vecs[v].sel*ADDR_W +: ADDR_W] = 11'h155;
      check("tbl_bound", bound, 1);
      check("tbl_invalid", ep_invalid, vecs[v].inv);
      check("tbl_stall", stall, vecs[v].inv);
      check("tbl_mode", endp_mode, vecs[v].mode);
      check("tbl_q", buf_out_q, vecs[v].q);
      check("tbl_hasdata", buf_out_hasdata, vecs[v].hd);
      check("tbl_len", buf_out_len, vecs[v].inv ? 0 : 100 + vecs[v].sel);
      check("tbl_in_addr", ep_buf_in_addr, e_addr);
      tick();
      buf_in_addr = '0;
      unbind();
      @(negedge phy_clk);
      check("tbl_unbound", bound, 0);
      tick();
    end

    // Arm handshake on ep3, endpoint acking two cycles after the arm appears.
    arm_seen = 0; acks = 0; other = 0; ack_cyc = -1; given_cyc = -1;
    sel_endp = 4'd3; xfer_start = 1'b1; buf_out_arm = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ep_buf_out_arm_ack = (arm_seen == 2) ? 4'b1000 : 4'b0000;
      if (arm_seen == 2) given_cyc = c;
      @(negedge phy_clk);
      if (ep_buf_out_arm[3]) arm_seen++;
      if (ep_buf_out_arm[2:0] != 3'b000) other++;
      if (buf_out_arm_ack) begin acks++; ack_cyc = c; end
      tick();
      xfer_start = 1'b0;
      if (c == 1) buf_out_arm = 1'b0;
    end
    ep_buf_out_arm_ack = 4'b0000;
    check("arm_high_cycles", arm_seen, 3);
    check("arm_ack_pulses", acks, 1);
    check("arm_other_eps", other, 0);
    check("arm_ack_latency", ack_cyc, given_cyc + 1);
    check("arm_still_bound", bound, 1);
    unbind();

    // Toggles: bulk ep1 alternates, isoch ep3 stays DATA0.
    tog_exp = 3'b101;
    bind_ep(4'd1);
    for (int k = 0; k < 3; k++) begin
      data_toggle_act = 1'b1;
      tick();
      data_toggle_act = 1'b0;
      @(negedge phy_clk);
      check("tog_bulk", data_toggle, {1'b0, tog_exp[k]});
      tick();
    end
    unbind();
    bind_ep(4'd3);
    for (int k = 0; k < 2; k++) begin
      data_toggle_act = 1'b1;
      tick();
      data_toggle_act = 1'b0;
      @(negedge phy_clk);
      check("tog_isoch", data_toggle, 0);
    end
    unbind();
    bind_ep(4'd2);
    data_toggle_act = 1'b1; xfer_end = 1'b1;
    tick();
    data_toggle_act = 1'b0; xfer_end = 1'b0;
    @(negedge phy_clk);
    check("tog_end_unbound", bound, 0);
    tick();
    bind_ep(4'd2);
    @(negedge phy_clk);
    check("tog_with_end", data_toggle, 1);
    tick();
    unbind();

    // Halt: ep0 and out-of-range ignored, halted ep1 stalls, clear resets its toggle.
    halt_set = 1'b1; halt_ep = 4'd1;
    tick();
    halt_ep = 4'd0;
    tick();
    halt_ep = 4'd7;
    tick();
    halt_set = 1'b0;
    @(negedge phy_clk);
    check("halt_flags", ep_halted, 4'b0010);
    tick();
    bind_ep(4'd1);
    @(negedge phy_clk);
    check("halt_stall", stall, 1);
    check("halt_hasdata", buf_out_hasdata, 0);
    check("halt_ready", buf_in_ready, 0);
    check("halt_tog_kept", data_toggle, 1);
    tick();
    halt_clr = 1'b1; halt_ep = 4'd1;
    tick();
    halt_clr = 1'b0;
    @(negedge phy_clk);
    check("halt_cleared", ep_halted, 0);
    check("halt_clr_tog", data_toggle, 0);
    check("halt_clr_stall", stall, 0);
    tick();
    unbind();
    halt_set = 1'b1; halt_clr = 1'b1; halt_ep = 4'd2;
    tick();
    halt_set = 1'b0; halt_clr = 1'b0;
    bind_ep(4'd2);
    @(negedge phy_clk);
    check("halt_set_wins", ep_halted, 4'b0100);
    check("halt_set_tog", data_toggle, 1);
    tick();
    halt_clr = 1'b1;
    tick();
    halt_clr = 1'b0;
    unbind();

    // Invalid endpoint: nothing forwarded, arm acked by the router.
    ep_buf_in_commit_ack = 4'b1111;
    buf_in_addr = 11'h7FF; buf_in_data = 8'hFF; buf_in_wren = 1'b1; buf_in_commit = 1'b1;
    buf_in_commit_len = 11'h7FF; buf_out_addr = 11'h7FF;
    bind_ep(4'd9);
    buf_out_arm = 1'b1;
    @(negedge phy_clk);
    check("inv_flag", ep_invalid, 1);
    check("inv_stall", stall, 1);
    check("inv_ep_outs", any_ep_out(), 0);
    check("inv_returns", {buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_q}, 0);
    tick();
    buf_out_arm = 1'b0;
    @(negedge phy_clk);
    check("inv_arm_ack", buf_out_arm_ack, 1);
    check("inv_arm_fwd", ep_buf_out_arm, 0);
    tick();
    @(negedge phy_clk);
    check("inv_ack_one", buf_out_arm_ack, 0);
    tick();
    pkt_idle();
    ep_defaults();
    unbind();

    // xfer_end during the arm wait: ack still delivered, then unbound.
    bind_ep(4'd2);
    buf_out_arm = 1'b1;
    tick();
    buf_out_arm = 1'b0; xfer_end = 1'b1;
    tick();
    xfer_end = 1'b0;
    @(negedge phy_clk);
    check("endarm_bound", bound, 1);
    check("endarm_arm", ep_buf_out_arm, 4'b0100);
    tick();
    ep_buf_out_arm_ack = 4'b0100;
    tick();
    ep_buf_out_arm_ack = 4'b0000;
    @(negedge phy_clk);
    check("endarm_ack", buf_out_arm_ack, 1);
    check("endarm_ack_bound", bound, 1);
    tick();
    @(negedge phy_clk);
    check("endarm_unbound", bound, 0);
    tick();

    // Reset mid-arm drops the arm at once.
    bind_ep(4'd1);
    buf_out_arm = 1'b1;
    tick();
    buf_out_arm = 1'b0;
    @(negedge phy_clk);
    check("rstarm_pre", ep_buf_out_arm, 4'b0010);
    #2 reset_n = 1'b0;
    #1;
    check("rstarm_drop", ep_buf_out_arm, 0);
    check("rstarm_bound", bound, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Randomized run against the model.
    m_bound = 0; m_ep = 0;
    for (int i = 0; i < NUM_EP; i++) begin m_tog[i] = 0; m_halt[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      xfer_start = ($urandom_range(0, 3) == 0);
      xfer_end = ($urandom_range(0, 5) == 0);
      sel_endp = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      data_toggle_act = $urandom_range(0, 1) == 1;
      halt_set = ($urandom_range(0, 7) == 0);
      halt_clr = ($urandom_range(0, 7) == 0);
      halt_ep = 4'($urandom_range(0, 7));
      buf_in_addr = ADDR_W'($urandom); buf_in_data = 8'($urandom);
      buf_in_wren = 1'($urandom); buf_in_commit = 1'($urandom);
      buf_in_commit_len = LEN_W'($urandom); buf_out_addr = ADDR_W'($urandom);
      ep_buf_out_q = 32'($urandom); ep_buf_out_len = 44'({$urandom, $urandom});
      ep_buf_out_hasdata = 4'($urandom); ep_buf_in_ready = 4'($urandom);
      ep_buf_in_commit_ack = 4'($urandom); ep_buf_out_arm_ack = 4'($urandom);
      @(negedge phy_clk);
      e_valid = m_bound && m_ep < NUM_EP;
      e_addr = '0; e_oaddr = '0; e_data = '0; e_wren = '0; e_commit = '0; e_clen = '0;
      for (int i = 0; i < NUM_EP; i++) e_halted[i] = m_halt[i];
      if (e_valid) begin
        e_addr[m_ep*ADDR_W +: ADDR_W] = buf_in_addr;
        e_oaddr[m_ep*ADDR_W +: ADDR_W] = buf_out_addr;
        e_data[m_ep*8 +: 8] = buf_in_data;
        e_wren[m_ep] = buf_in_wren;
        e_commit[m_ep] = buf_in_commit;
        e_clen[m_ep*LEN_W +: LEN_W] = buf_in_commit_len;
      end
      check("r_bound", bound, m_bound);
      check("r_invalid", ep_invalid, m_bound && m_ep >= NUM_EP);
      check("r_mode", endp_mode, e_valid ? mode_tab[m_ep] : 0);
      check("r_stall", stall, (m_bound && m_ep >= NUM_EP) || (e_valid && m_halt[m_ep]));
      check("r_toggle", data_toggle, e_valid ? m_tog[m_ep] : 0);
      check("r_halted", ep_halted, e_halted);
      check("r_q", buf_out_q, e_valid ? ep_buf_out_q[m_ep*8 +: 8] : 0);
      check("r_len", buf_out_len, e_valid ? ep_buf_out_len[m_ep*LEN_W +: LEN_W] : 0);
      check("r_hasdata", buf_out_hasdata, e_valid && !m_halt[m_ep] && ep_buf_out_hasdata[m_ep]);
      check("r_ready", buf_in_ready, e_valid && !m_halt[m_ep] && ep_buf_in_ready[m_ep]);
      check("r_cack", buf_in_commit_ack, e_valid && ep_buf_in_commit_ack[m_ep]);
      check("r_in_addr", ep_buf_in_addr, e_addr);
      check("r_out_addr", ep_buf_out_addr, e_oaddr);
      check("r_in_data", ep_buf_in_data, e_data);
      check("r_wren_commit", {ep_buf_in_wren, ep_buf_in_commit}, {e_wren, e_commit});
      check("r_clen", ep_buf_in_commit_len, e_clen);
      check("r_arm", ep_buf_out_arm, 0);
      if (e_valid && data_toggle_act && mode_tab[m_ep] != 1) m_tog[m_ep] = !m_tog[m_ep];
      he = int'(halt_ep);
      if (he >= 1 && he < NUM_EP) begin
        if (halt_set) m_halt[he] = 1;
        else if (halt_clr) begin m_halt[he] = 0; m_tog[he] = 0; end
      end
      if (!m_bound) begin
        if (xfer_start) begin m_bound = 1; m_ep = int'(sel_endp); end
      end else if (xfer_end) begin
        m_bound = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
